seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
Multiplexed 4-digit seven-segment display driver. It sits directly downstream of the hex-value sources and replaces the fixed single-digit enable with a time-multiplexed scan of all four digits. It includes a built-in hex-to-segment decoder, per-digit blanking, a decimal point per digit, and an inter-digit dead time to suppress ghosting. New display data is double-buffered and applied only at a frame boundary, so the display never tears.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (4 slots per frame); legal range 2..2^20.
BLANK_CYCLES, 250, dead-time cycles at the start of each slot with all digits off; must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
FPGA_CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
DIGIT_DATA  in  16  four hex nibbles; [15:12]=DIG1 (leftmost) .. [3:0]=DIG4
DIGIT_EN  in  4  per-digit enable; [3]=DIG1 .. [0]=DIG4; 0 blanks that digit
DP_IN  in  4  per-digit decimal point; [3]=DIG1 .. [0]=DIG4; 1 lights the DP
LOAD  in  1  one-cycle strobe; captures DIGIT_DATA/DIGIT_EN/DP_IN into the pending buffer
LOAD_ACK  out  1  one-cycle pulse when the pending buffer is committed to the display
FRAME_TICK  out  1  one-cycle pulse at the start of each frame (slot 0, counter 0)
SVNSEG_DIG1..SVNSEG_DIG4  out  1 each  digit common select, active-low
SVNSEG_SEG0..SVNSEG_SEG6  out  1 each  segments a..g, active-low
SVNSEG_SEG7  out  1  decimal point, active-low

Behaviour:
- Reset is asynchronous on RST_N low. While it is asserted:
  - slot index = 0, slot counter = 0;
  - display buffer and pending buffer = 0; pending_valid = 0;
  - all DIG and SEG outputs = 1 (dark); LOAD_ACK = 0, FRAME_TICK = 0.
- Slot counter: counts 0..REFRESH_DIV-1. On reaching REFRESH_DIV-1 it wraps to 0 and the slot index increments 0->1->2->3->0 (2-bit wrap).
- Phases within a slot: BLANK while counter < BLANK_CYCLES; DRIVE while counter >= BLANK_CYCLES.
- BLANK phase: all DIG = 1, all SEG = 1.
- DRIVE phase with slot index i and display-buffer enable for digit i+1 equal to 1:
  - DIG(i+1) = 0; the other three DIG = 1.
  - SEG0..6 = ~decode(nibble i+1).
  - SEG7 = ~dp(i+1).
- DRIVE phase with that enable equal to 0: all DIG = 1, all SEG = 1.
- Decode table, bit 6 = segment a ... bit 0 = segment g:
  - 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70
  - 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47
- All DIG/SEG outputs are registered. Each output reflects the counter/index state of the previous cycle (1-cycle latency). No combinational path from any input to any output.
- LOAD handling:
  - A LOAD strobe overwrites the pending buffer and sets pending_valid.
  - Multiple LOADs within one frame: the last one wins.
  - LOAD is sampled every cycle with no backpressure.
- Commit:
  - Condition: slot index = 3, counter = REFRESH_DIV-1, and pending_valid = 1.
  - On that edge: display buffer <= pending buffer, pending_valid <= 0, LOAD_ACK pulses next cycle.
  - New data is first visible in slot 0 of the following frame.
  - LOAD on the exact commit edge: that LOAD's data goes to pending (pending_valid stays 1), and the previously pending data is committed.
- FRAME_TICK: registered; high for exactly one cycle following the edge where the counter wraps from slot 3 to slot 0.
- Reset asserted mid-frame or mid-pending: outputs go dark immediately, pending data is lost, and the scan restarts at slot 0 BLANK on release.
- Counter width: $clog2(REFRESH_DIV). There is no terminal-count overflow beyond REFRESH_DIV-1.

Test Plan:
- Scenario 1: REFRESH_DIV=8, BLANK_CYCLES=2. Reset, release, LOAD DIGIT_DATA=16'h1234, EN=4'hF, DP=0 -> first frame fully dark; LOAD_ACK pulses once. Next frame: each slot shows 2 dark cycles then 6 cycles of DIG1..DIG4 = 0 in turn, with SEG0..6 = ~30, ~6D, ~79, ~33 respectively and SEG7 = 1.
- Scenario 2: DIGIT_EN=4'b1010, DATA=16'hABCD -> slots 0 and 2 drive ~77 and ~4E; slots 1 and 3 are fully dark (all DIG and SEG = 1).
- Scenario 3: DP_IN=4'b0001, DATA=16'h0008 -> only the DIG4 slot shows SEG7 = 0 with SEG0..6 = ~7F = 0; SEG7 = 1 in all other slots.
- Scenario 4: LOAD 16'h1111 then 16'h2222 in the same frame -> exactly one LOAD_ACK; the display shows 2222 and never 1111.
- Scenario 5: LOAD 16'h5555 on the commit edge while 16'h4444 is pending -> frame N+1 shows 4444 (LOAD_ACK), frame N+2 shows 5555 (second LOAD_ACK).
- Scenario 6: assert RST_N low during slot 2 DRIVE -> all outputs = 1 within the same cycle (asynchronous). After release, FRAME_TICK first pulses after 4*REFRESH_DIV cycles, and the display stays dark until a new LOAD is committed.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit time-multiplexed seven-segment driver with hex decode,
// per-digit blanking/DP, inter-digit dead time and frame-synchronous double buffering.
module seven_seg_scan #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 250
) (
   input  logic        FPGA_CLK,
   input  logic        RST_N,
   input  logic [15:0] DIGIT_DATA,
   input  logic [3:0]  DIGIT_EN,
   input  logic [3:0]  DP_IN,
   input  logic        LOAD,
   output logic        LOAD_ACK,
   output logic        FRAME_TICK,
   output logic        SVNSEG_DIG1,
   output logic        SVNSEG_DIG2,
   output logic        SVNSEG_DIG3,
   output logic        SVNSEG_DIG4,
   output logic        SVNSEG_SEG0,
   output logic        SVNSEG_SEG1,
   output logic        SVNSEG_SEG2,
   output logic        SVNSEG_SEG3,
   output logic        SVNSEG_SEG4,
   output logic        SVNSEG_SEG5,
   output logic        SVNSEG_SEG6,
   output logic        SVNSEG_SEG7
);
   localparam int CW = $clog2(REFRESH_DIV);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    slot_q, slot_d;
   // buffers packed as {data[15:0], en[3:0], dp[3:0]}
   logic [23:0]   disp_q, disp_d, pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic [3:0]    dig_q, dig_d;
   logic [7:0]    seg_q, seg_d;
   logic          ack_q, tick_q;
   logic          slot_end, frame_end, commit, drive;
   logic [3:0]    nib;
   logic [6:0]    dec;
   always_comb begin
      slot_end   = cnt_q == CW'(REFRESH_DIV - 1);
      frame_end  = slot_end && slot_q == 2'd3;
      commit     = frame_end && pend_vld_q;
      cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
      slot_d     = slot_end ? slot_q + 2'd1 : slot_q;
      pend_d     = LOAD ? {DIGIT_DATA, DIGIT_EN, DP_IN} : pend_q;
      pend_vld_d = LOAD | (pend_vld_q & ~commit);
      disp_d     = commit ? pend_q : disp_q;
      nib        = disp_q[{~slot_q, 2'b00} + 5'd8 +: 4];
      drive      = cnt_q >= CW'(BLANK_CYCLES) && disp_q[{1'b1, ~slot_q}];
   end
   always_comb begin
      dec = 7'h00;
      case (nib)
         4'h0: dec = 7'h7E;
         4'h1: dec = 7'h30;
         4'h2: dec = 7'h6D;
         4'h3: dec = 7'h79;
         4'h4: dec = 7'h33;
         4'h5: dec = 7'h5B;
         4'h6: dec = 7'h5F;
         4'h7: dec = 7'h70;
         4'h8: dec = 7'h7F;
         4'h9: dec = 7'h7B;
         4'hA: dec = 7'h77;
         4'hB: dec = 7'h1F;
         4'hC: dec = 7'h4E;
         4'hD: dec = 7'h3D;
         4'hE: dec = 7'h4F;
         4'hF: dec = 7'h47;
         default: dec = 7'h00;
      endcase
      dig_d = drive ? ~(4'b1000 >> slot_q) : 4'hF;
      seg_d = drive ? {~disp_q[~slot_q], ~dec} : 8'hFF;
   end
   always_ff @(posedge FPGA_CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q      <= '0;
         slot_q     <= '0;
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         dig_q      <= 4'hF;
         seg_q      <= 8'hFF;
         ack_q      <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         slot_q     <= slot_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         dig_q      <= dig_d;
         seg_q      <= seg_d;
         ack_q      <= commit;
         tick_q     <= frame_end;
      end
   end
   assign LOAD_ACK    = ack_q;
   assign FRAME_TICK  = tick_q;
   assign SVNSEG_DIG1 = dig_q[3];
   assign SVNSEG_DIG2 = dig_q[2];
   assign SVNSEG_DIG3 = dig_q[1];
   assign SVNSEG_DIG4 = dig_q[0];
   assign SVNSEG_SEG0 = seg_q[6];
   assign SVNSEG_SEG1 = seg_q[5];
   assign SVNSEG_SEG2 = seg_q[4];
   assign SVNSEG_SEG3 = seg_q[3];
   assign SVNSEG_SEG4 = seg_q[2];
   assign SVNSEG_SEG5 = seg_q[1];
   assign SVNSEG_SEG6 = seg_q[0];
   assign SVNSEG_SEG7 = seg_q[7];
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed scenarios for seven_seg_scan; expected frames are queued
// per load and compared sample-by-sample as the scan produces them.
module tb_seven_seg_scan;
   localparam int RD = 8;
   localparam int BC = 2;
   logic        FPGA_CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [15:0] DIGIT_DATA = '0;
   logic [3:0]  DIGIT_EN = '0;
   logic [3:0]  DP_IN = '0;
   logic        LOAD = 1'b0;
   logic        LOAD_ACK, FRAME_TICK;
   logic        SVNSEG_DIG1, SVNSEG_DIG2, SVNSEG_DIG3, SVNSEG_DIG4;
   logic        SVNSEG_SEG0, SVNSEG_SEG1, SVNSEG_SEG2, SVNSEG_SEG3;
   logic        SVNSEG_SEG4, SVNSEG_SEG5, SVNSEG_SEG6, SVNSEG_SEG7;
   logic [11:0] obs;
   logic [11:0] sb[$];
   logic [6:0]  dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
   int total = 0;
   int bad = 0;
   int ack_cnt = 0;
   int a0;

   seven_seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .FPGA_CLK(FPGA_CLK), .RST_N(RST_N), .DIGIT_DATA(DIGIT_DATA), .DIGIT_EN(DIGIT_EN),
      .DP_IN(DP_IN), .LOAD(LOAD), .LOAD_ACK(LOAD_ACK), .FRAME_TICK(FRAME_TICK),
      .SVNSEG_DIG1(SVNSEG_DIG1), .SVNSEG_DIG2(SVNSEG_DIG2), .SVNSEG_DIG3(SVNSEG_DIG3),
      .SVNSEG_DIG4(SVNSEG_DIG4), .SVNSEG_SEG0(SVNSEG_SEG0), .SVNSEG_SEG1(SVNSEG_SEG1),
      .SVNSEG_SEG2(SVNSEG_SEG2), .SVNSEG_SEG3(SVNSEG_SEG3), .SVNSEG_SEG4(SVNSEG_SEG4),
      .SVNSEG_SEG5(SVNSEG_SEG5), .SVNSEG_SEG6(SVNSEG_SEG6), .SVNSEG_SEG7(SVNSEG_SEG7)
   );

   // {DIG1..DIG4, SEG7, SEG0..SEG6}
   assign obs = {SVNSEG_DIG1, SVNSEG_DIG2, SVNSEG_DIG3, SVNSEG_DIG4, SVNSEG_SEG7,
                 SVNSEG_SEG0, SVNSEG_SEG1, SVNSEG_SEG2, SVNSEG_SEG3, SVNSEG_SEG4,
                 SVNSEG_SEG5, SVNSEG_SEG6};

   always #5 FPGA_CLK = ~FPGA_CLK;
   always @(posedge FPGA_CLK) if (LOAD_ACK === 1'b1) ack_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(negedge FPGA_CLK);
      if (sb.size() > 0) chk("scan", obs, sb.pop_front());
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic frame(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
      logic [3:0] dig;
      for (int s = 0; s < 4; s++)
         for (int c = 0; c < RD; c++) begin
            dig = 4'hF;
            dig[3-s] = 1'b0;
            if (c < BC || !e[3-s]) sb.push_back(12'hFFF);
            else sb.push_back({dig, ~p[3-s], ~dec_tab[d[15-4*s -: 4]]});
         end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
      DIGIT_DATA = d;
      DIGIT_EN = e;
      DP_IN = p;
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
   endtask

   task automatic wait_tick(input logic exp_ack);
      int n = 0;
      while (FRAME_TICK !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("tick_delay", n, 0);
      chk("ack", LOAD_ACK, exp_ack);
   endtask

   task automatic load_and_show(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
      do_load(d, e, p);
      steps(4 * RD - 1);
      wait_tick(1'b1);
      frame(d, e, p);
      steps(4 * RD);
      wait_tick(1'b0);
   endtask

   initial begin
      repeat (3) @(negedge FPGA_CLK);
      chk("rst_out", obs, 12'hFFF);
      chk("rst_ack", LOAD_ACK, 1'b0);
      chk("rst_tick", FRAME_TICK, 1'b0);
      RST_N = 1'b1;
      // scenario 1: first frame dark while 1234 is pending
      frame(16'h0, 4'h0, 4'h0);
      do_load(16'h1234, 4'hF, 4'h0);
      steps(4 * RD - 1);
      wait_tick(1'b1);
      frame(16'h1234, 4'hF, 4'h0);
      steps(4 * RD);
      wait_tick(1'b0);
      // scenarios 2 and 3
      load_and_show(16'hABCD, 4'b1010, 4'h0);
      load_and_show(16'h0008, 4'hF, 4'b0001);
      // scenario 4: last load in a frame wins, one ack
      a0 = ack_cnt;
      do_load(16'h1111, 4'hF, 4'h0);
      steps(5);
      do_load(16'h2222, 4'hF, 4'h0);
      steps(4 * RD - 7);
      wait_tick(1'b1);
      frame(16'h2222, 4'hF, 4'h0);
      steps(4 * RD);
      wait_tick(1'b0);
      chk("ack_count", ack_cnt - a0, 1);
      // scenario 5: load on the commit edge stays pending
      do_load(16'h4444, 4'hF, 4'h0);
      steps(4 * RD - 2);
      do_load(16'h5555, 4'hF, 4'h0);
      wait_tick(1'b1);
      frame(16'h4444, 4'hF, 4'h0);
      steps(4 * RD);
      wait_tick(1'b1);
      frame(16'h5555, 4'hF, 4'h0);
      steps(4 * RD);
      wait_tick(1'b0);
      // scenario 6: async reset during slot 2 drive with data pending
      steps(2 * RD + BC + 2);
      chk("dig_slot2", obs[11:8], 4'b1101);
      do_load(16'h6666, 4'hF, 4'h0);
      #2 RST_N = 1'b0;
      #1 chk("async_out", obs, 12'hFFF);
      chk("async_ack", LOAD_ACK, 1'b0);
      chk("async_tick", FRAME_TICK, 1'b0);
      repeat (2) @(negedge FPGA_CLK);
      RST_N = 1'b1;
      frame(16'h0, 4'h0, 4'h0);
      steps(4 * RD);
      wait_tick(1'b0);
      frame(16'h0, 4'h0, 4'h0);
      steps(4 * RD);
      wait_tick(1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
